// File: rtl/ecg_pair_buffer_if.sv
// Sample-buffer bus: write stream in, single/pair read requests and status out.
interface ecg_pair_buffer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
);
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              rd_req;
   logic              rd_mode;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data0;
   logic [DATA_W-1:0] rd_data1;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_valid, wr_data, rd_req, rd_mode,
      input  wr_ready, rd_ready, rd_valid, rd_data0, rd_data1,
             count, full, empty, overflow, underflow
   );

   modport slave (
      input  wr_valid, wr_data, rd_req, rd_mode,
      output wr_ready, rd_ready, rd_valid, rd_data0, rd_data1,
             count, full, empty, overflow, underflow
   );
endinterface

// File: rtl/ecg_pair_buffer.sv
// Circular ECG sample buffer split into even/odd banks so a pair (n, n+1)
// comes out in one read. Two-stage read: bank read, then output mux register.
module ecg_pair_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
) (
   input logic          clk,
   input logic          rst,
   ecg_pair_buffer_if.slave bus
);
   localparam int              BANK_D = 1 << (ADDR_W - 1);
   localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
   localparam int              STAGES = 2;

   logic [ADDR_W-1:0]        wr_ptr, rd_ptr, rd_ptr_p1;
   logic [ADDR_W:0]          count_q;
   logic [DATA_W-1:0]        mem [2][BANK_D];
   logic [1:0][DATA_W-1:0]   bank_q;
   logic [1:0][ADDR_W-2:0]   raddr;
   logic [STAGES:1]          vld_pipe;
   logic                     sel_q, mode_q;
   logic                     full, empty, rd_ready, wr_acc, rd_acc;
   logic [1:0]               rd_cnt;
   logic [DATA_W-1:0]        rd_data0_q, rd_data1_q;
   logic                     ovf_q, udf_q;

   assign full      = (count_q == DEPTH);
   assign empty     = (count_q == '0);
   assign rd_ready  = bus.rd_mode ? (count_q >= (ADDR_W+1)'(2)) : !empty;
   // Full is registered, so a same-cycle read never frees room for a write.
   assign wr_acc    = bus.wr_valid && !full;
   assign rd_acc    = bus.rd_req && rd_ready;
   assign rd_cnt    = rd_acc ? (bus.rd_mode ? 2'd2 : 2'd1) : 2'd0;
   assign rd_ptr_p1 = rd_ptr + ADDR_W'(1);

   // Bank holding rd_ptr reads at rd_ptr>>1; the other bank serves rd_ptr+1,
   // which covers the wrap from the last slot back to slot 0.
   always_comb begin
      raddr = '0;
      for (int b = 0; b < 2; b++)
         raddr[b] = (rd_ptr[0] == 1'(b)) ? rd_ptr[ADDR_W-1:1] : rd_ptr_p1[ADDR_W-1:1];
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !rst)
         mem[wr_ptr[0]][wr_ptr[ADDR_W-1:1]] <= bus.wr_data;
      if (rd_acc && !rst) begin
         for (int b = 0; b < 2; b++)
            bank_q[b] <= mem[b][raddr[b]];
         sel_q  <= rd_ptr[0];
         mode_q <= bus.rd_mode;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         vld_pipe   <= '0;
         rd_data0_q <= '0;
         rd_data1_q <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + (bus.rd_mode ? ADDR_W'(2) : ADDR_W'(1));
         count_q  <= count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_cnt);
         vld_pipe <= {vld_pipe[STAGES-1:1], rd_acc};
         if (vld_pipe[1]) begin
            rd_data0_q <= bank_q[sel_q];
            rd_data1_q <= mode_q ? bank_q[~sel_q] : '0;
         end
         if (bus.wr_valid && full)    ovf_q <= 1'b1;
         if (bus.rd_req && !rd_ready) udf_q <= 1'b1;
      end
   end

   assign bus.wr_ready  = !full;
   assign bus.rd_ready  = rd_ready;
   assign bus.rd_valid  = vld_pipe[STAGES];
   assign bus.rd_data0  = rd_data0_q;
   assign bus.rd_data1  = rd_data1_q;
   assign bus.count     = count_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;
endmodule

// File: tb/tb_ecg_pair_buffer.sv
// Directed bench for ecg_pair_buffer at depth 8: pair reads, overflow, wrap,
// simultaneous write/read, underflow and reset during an in-flight read.
module tb_ecg_pair_buffer;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ecg_pair_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
   ecg_pair_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wr(input logic [31:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      step();
      bus.wr_valid = 1'b0;
   endtask

   // Accept edge, then data appears after the following edge.
   task automatic rd(input logic mode, input logic [31:0] e0, input logic [31:0] e1, input string tag);
      bus.rd_req  = 1'b1;
      bus.rd_mode = mode;
      step();
      bus.rd_req  = 1'b0;
      chk({tag, "_vld_early"}, 32'(bus.rd_valid), 32'd0);
      step();
      chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
      chk({tag, "_d0"}, bus.rd_data0, e0);
      chk({tag, "_d1"}, bus.rd_data1, e1);
   endtask

   initial begin
      rst = 1'b1;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_req   = 1'b0;
      bus.rd_mode  = 1'b0;
      step();

      // Reset state
      do_reset();
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_d0", bus.rd_data0, 32'd0);
      chk("rst_d1", bus.rd_data1, 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      chk("rst_udf", 32'(bus.underflow), 32'd0);

      // 1. Pair reads
      for (int i = 0; i < 4; i++) wr(32'h10 + 32'(i));
      chk("t1_count4", 32'(bus.count), 32'd4);
      rd(1'b1, 32'h10, 32'h11, "t1_p0");
      chk("t1_count2", 32'(bus.count), 32'd2);
      rd(1'b1, 32'h12, 32'h13, "t1_p1");
      chk("t1_count0", 32'(bus.count), 32'd0);
      chk("t1_empty", 32'(bus.empty), 32'd1);
      step();
      chk("t1_vld_pulse", 32'(bus.rd_valid), 32'd0);
      chk("t1_hold_d0", bus.rd_data0, 32'h12);

      // 2. Overflow
      do_reset();
      for (int i = 0; i < 8; i++) wr(32'(i));
      chk("t2_full", 32'(bus.full), 32'd1);
      chk("t2_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("t2_count8", 32'(bus.count), 32'd8);
      chk("t2_ovf_pre", 32'(bus.overflow), 32'd0);
      wr(32'hFF);
      chk("t2_ovf", 32'(bus.overflow), 32'd1);
      chk("t2_count_keep", 32'(bus.count), 32'd8);
      rd(1'b0, 32'h00, 32'h00, "t2_s0");
      chk("t2_count7", 32'(bus.count), 32'd7);
      chk("t2_ovf_sticky", 32'(bus.overflow), 32'd1);

      // 3. Wrap with bank straddle
      do_reset();
      for (int i = 0; i < 7; i++) wr(32'h20 + 32'(i));
      for (int i = 0; i < 7; i++) rd(1'b0, 32'h20 + 32'(i), 32'd0, "t3_s");
      chk("t3_empty", 32'(bus.empty), 32'd1);
      for (int i = 0; i < 4; i++) wr(32'hA0 + 32'(i));
      rd(1'b1, 32'hA0, 32'hA1, "t3_wrap");
      rd(1'b1, 32'hA2, 32'hA3, "t3_p1");
      chk("t3_count0", 32'(bus.count), 32'd0);

      // 4. Simultaneous write and pair read
      do_reset();
      for (int i = 0; i < 3; i++) wr(32'h30 + 32'(i));
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'h55;
      bus.rd_req   = 1'b1;
      bus.rd_mode  = 1'b1;
      step();
      bus.wr_valid = 1'b0;
      bus.rd_req   = 1'b0;
      chk("t4_count2", 32'(bus.count), 32'd2);
      step();
      chk("t4_vld", 32'(bus.rd_valid), 32'd1);
      chk("t4_d0", bus.rd_data0, 32'h30);
      chk("t4_d1", bus.rd_data1, 32'h31);
      rd(1'b1, 32'h32, 32'h55, "t4_p1");
      chk("t4_count0", 32'(bus.count), 32'd0);

      // 5. Underflow
      do_reset();
      wr(32'h40);
      bus.rd_mode = 1'b1;
      #1;
      chk("t5_rd_ready_pair", 32'(bus.rd_ready), 32'd0);
      bus.rd_req = 1'b1;
      step();
      bus.rd_req = 1'b0;
      chk("t5_udf", 32'(bus.underflow), 32'd1);
      chk("t5_count1", 32'(bus.count), 32'd1);
      step();
      chk("t5_no_vld", 32'(bus.rd_valid), 32'd0);
      rd(1'b0, 32'h40, 32'd0, "t5_s");
      chk("t5_count0", 32'(bus.count), 32'd0);

      // 6. Reset during an in-flight pair read; requests under reset are ignored
      do_reset();
      wr(32'h60);
      wr(32'h61);
      bus.rd_req  = 1'b1;
      bus.rd_mode = 1'b1;
      step();
      rst          = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'h99;
      step();
      rst          = 1'b0;
      bus.rd_req   = 1'b0;
      bus.wr_valid = 1'b0;
      chk("t6_vld", 32'(bus.rd_valid), 32'd0);
      chk("t6_count", 32'(bus.count), 32'd0);
      chk("t6_ovf", 32'(bus.overflow), 32'd0);
      chk("t6_udf", 32'(bus.underflow), 32'd0);
      chk("t6_d0", bus.rd_data0, 32'd0);
      step();
      chk("t6_vld_late", 32'(bus.rd_valid), 32'd0);
      chk("t6_udf_late", 32'(bus.underflow), 32'd0);
      wr(32'h77);
      rd(1'b0, 32'h77, 32'd0, "t6_s");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
